// File: rtl/sid_pkg.sv
// -----------------------------------------------------------------------------
// sid_pkg
// Shared definitions for the SID bus slave: register address map, register
// count, bus-access FSM state encoding and the bit layout of the synchronized
// bus bundle.
// -----------------------------------------------------------------------------
package sid_pkg;

    localparam int SID_NUM_REGS = 25;  // writable registers 0x00..0x18

    // Voice 1
    localparam logic [4:0] SID_ADDR_FREQLO1 = 5'h00, SID_ADDR_FREQHI1 = 5'h01;
    localparam logic [4:0] SID_ADDR_PWLO1   = 5'h02, SID_ADDR_PWHI1   = 5'h03;
    localparam logic [4:0] SID_ADDR_CR1     = 5'h04, SID_ADDR_AD1     = 5'h05;
    localparam logic [4:0] SID_ADDR_SR1     = 5'h06;
    // Voice 2
    localparam logic [4:0] SID_ADDR_FREQLO2 = 5'h07, SID_ADDR_FREQHI2 = 5'h08;
    localparam logic [4:0] SID_ADDR_PWLO2   = 5'h09, SID_ADDR_PWHI2   = 5'h0A;
    localparam logic [4:0] SID_ADDR_CR2     = 5'h0B, SID_ADDR_AD2     = 5'h0C;
    localparam logic [4:0] SID_ADDR_SR2     = 5'h0D;
    // Voice 3
    localparam logic [4:0] SID_ADDR_FREQLO3 = 5'h0E, SID_ADDR_FREQHI3 = 5'h0F;
    localparam logic [4:0] SID_ADDR_PWLO3   = 5'h10, SID_ADDR_PWHI3   = 5'h11;
    localparam logic [4:0] SID_ADDR_CR3     = 5'h12, SID_ADDR_AD3     = 5'h13;
    localparam logic [4:0] SID_ADDR_SR3     = 5'h14;
    // Filter / volume
    localparam logic [4:0] SID_ADDR_FCLO    = 5'h15, SID_ADDR_FCHI    = 5'h16;
    localparam logic [4:0] SID_ADDR_RESFILT = 5'h17, SID_ADDR_MODEVOL = 5'h18;
    // Read-only sources
    localparam logic [4:0] SID_ADDR_POTX    = 5'h19, SID_ADDR_POTY    = 5'h1A;
    localparam logic [4:0] SID_ADDR_OSC3    = 5'h1B, SID_ADDR_ENV3    = 5'h1C;

    // Synchronized bundle: {data[15:8], addr[7:3], rw[2], notcs[1], phi2[0]}
    localparam int SID_SYNC_W    = 16;
    localparam int SID_SYNC_PHI2 = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } sid_state_e;

    function automatic logic sid_is_reg_addr(input logic [4:0] addr);
        return addr <= SID_ADDR_MODEVOL;
    endfunction

endpackage

// File: rtl/sid_bus_sync.sv
// -----------------------------------------------------------------------------
// sid_bus_sync
// Multi-flop synchronizer for the whole SID bus bundle plus phi2 falling-edge
// detection in the system clock domain.
//   clk          system clock
//   rst_n        asynchronous active-low reset (clears every stage)
//   i_async      raw bus bundle (layout in sid_pkg)
//   o_sync       bundle after SYNC_STAGES flops
//   o_phi2_fall  one-cycle pulse on the first synced phi2=0 after phi2=1
// -----------------------------------------------------------------------------
module sid_bus_sync
    import sid_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // legal 2..4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SID_SYNC_W-1:0] i_async,
    output logic [SID_SYNC_W-1:0] o_sync,
    output logic                  o_phi2_fall
);

    logic [SYNC_STAGES-1:0][SID_SYNC_W-1:0] r_chain;
    logic                                   r_phi2_prev;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain     <= '0;
            r_phi2_prev <= 1'b0;
        end else begin
            r_chain     <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_phi2_prev <= r_chain[SYNC_STAGES-1][SID_SYNC_PHI2];
        end
    end

    assign o_sync      = r_chain[SYNC_STAGES-1];
    assign o_phi2_fall = r_phi2_prev & ~o_sync[SID_SYNC_PHI2];

endmodule

// File: rtl/sid_bus_slave.sv
// -----------------------------------------------------------------------------
// sid_bus_slave
// SID register-file bus slave. Synchronizes the asynchronous phi2 bus, commits
// writes on the phi2 falling edge into a 25-entry register array, serves reads
// of the read-only sources and exposes an internal registered read port.
//   C6_CLK_8MHZ / SID_NOTRES       system clock / async active-low reset
//   SID_CLK, SID_NOTCS, SID_RW,
//   SID_ADDR, SID_DATA_IN          bus from the master (asynchronous)
//   SID_DATA_OUT, SID_DATA_OE      read data and its output enable
//   POTX, POTY, OSC3, ENV3         read-only sources at 0x19..0x1C
//   WR_STB, WR_ADDR, WR_DATA       one-cycle notification of each committed write
//   REG_RADDR / REG_RDATA          internal read port, one-cycle latency
//   GATE                           bit 0 of control registers 0x04/0x0B/0x12
// Optional feature macro: SID_BUSDECAY_EN -- reads of write-only addresses
// return the last written byte, which decays to 0x00 after DECAY_CYCLES.
// -----------------------------------------------------------------------------
module sid_bus_slave
    import sid_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [21:0] DECAY_CYCLES = 22'd2000000
) (
    input  logic       C6_CLK_8MHZ,
    input  logic       SID_NOTRES,
    input  logic       SID_CLK,
    input  logic       SID_NOTCS,
    input  logic       SID_RW,
    input  logic [4:0] SID_ADDR,
    input  logic [7:0] SID_DATA_IN,
    output logic [7:0] SID_DATA_OUT,
    output logic       SID_DATA_OE,
    input  logic [7:0] POTX,
    input  logic [7:0] POTY,
    input  logic [7:0] OSC3,
    input  logic [7:0] ENV3,
    output logic       WR_STB,
    output logic [4:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    input  logic [4:0] REG_RADDR,
    output logic [7:0] REG_RDATA,
    output logic [2:0] GATE
);

    logic [SID_SYNC_W-1:0] w_sync;
    logic                  w_phi2, w_notcs, w_rw, w_phi2_fall;
    logic [4:0]            w_addr;
    logic [7:0]            w_din;

    sid_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (C6_CLK_8MHZ),
        .rst_n       (SID_NOTRES),
        .i_async     ({SID_DATA_IN, SID_ADDR, SID_RW, SID_NOTCS, SID_CLK}),
        .o_sync      (w_sync),
        .o_phi2_fall (w_phi2_fall)
    );

    assign w_phi2  = w_sync[0];
    assign w_notcs = w_sync[1];
    assign w_rw    = w_sync[2];
    assign w_addr  = w_sync[7:3];
    assign w_din   = w_sync[15:8];

    // ---------------- bus-access FSM ----------------
    sid_state_e r_state, w_next_state;

    always_ff @(posedge C6_CLK_8MHZ or negedge SID_NOTRES) begin
        if (!SID_NOTRES) r_state <= ST_IDLE;
        else             r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_phi2 && !w_notcs) w_next_state = ST_ARMED;
            ST_ARMED:  begin
                // Chip select dropping before the phi2 fall aborts the access.
                if (w_notcs)          w_next_state = ST_IDLE;
                else if (w_phi2_fall) w_next_state = ST_COMMIT;
            end
            ST_COMMIT: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Capture tracks the bus every selected phi2-high cycle, so at the fall it
    // holds the values of the last phi2=1 cycle.
    logic       r_cap_rw;
    logic [4:0] r_cap_addr;
    logic [7:0] r_cap_data;

    always_ff @(posedge C6_CLK_8MHZ or negedge SID_NOTRES) begin
        if (!SID_NOTRES) begin
            r_cap_rw   <= 1'b1;
            r_cap_addr <= '0;
            r_cap_data <= '0;
        end else if (w_phi2 && !w_notcs) begin
            r_cap_rw   <= w_rw;
            r_cap_addr <= w_addr;
            r_cap_data <= w_din;
        end
    end

    logic w_wr_en;

    always_comb begin
        w_wr_en = (r_state == ST_COMMIT) && !r_cap_rw && sid_is_reg_addr(r_cap_addr);
        WR_STB  = w_wr_en;
        WR_ADDR = w_wr_en ? r_cap_addr : 5'd0;
        WR_DATA = w_wr_en ? r_cap_data : 8'd0;
    end

    // ---------------- register array ----------------
    logic [7:0] r_regs [SID_NUM_REGS];
    logic [7:0] r_reg_rdata;

    // NOTE: the array is built from flops with an async clear because reset must
    // wipe the register contents; this deliberately rules out a RAM macro.
    always_ff @(posedge C6_CLK_8MHZ or negedge SID_NOTRES) begin
        if (!SID_NOTRES) begin
            for (int i = 0; i < SID_NUM_REGS; i++) r_regs[i] <= '0;
            r_reg_rdata <= '0;
        end else begin
            if (w_wr_en) r_regs[r_cap_addr] <= r_cap_data;
            // Reads the pre-commit value when colliding with a write.
            r_reg_rdata <= sid_is_reg_addr(REG_RADDR) ? r_regs[REG_RADDR] : 8'h00;
        end
    end

    assign REG_RDATA = r_reg_rdata;

    // GATE follows the write already in the commit cycle, ahead of the array.
    always_comb begin
        GATE = {r_regs[SID_ADDR_CR3][0], r_regs[SID_ADDR_CR2][0], r_regs[SID_ADDR_CR1][0]};
        if (w_wr_en) begin
            case (r_cap_addr)
                SID_ADDR_CR1: GATE[0] = r_cap_data[0];
                SID_ADDR_CR2: GATE[1] = r_cap_data[0];
                SID_ADDR_CR3: GATE[2] = r_cap_data[0];
                default:      ;
            endcase
        end
    end

    // ---------------- bus-hold value for write-only reads ----------------
    logic [7:0] w_bus_hold;

`ifdef SID_BUSDECAY_EN
    logic [7:0]  r_decay_byte;
    logic [21:0] r_decay_cnt;

    always_ff @(posedge C6_CLK_8MHZ or negedge SID_NOTRES) begin
        if (!SID_NOTRES) begin
            r_decay_byte <= '0;
            r_decay_cnt  <= '0;
        end else if (w_wr_en) begin
            r_decay_byte <= r_cap_data;
            r_decay_cnt  <= DECAY_CYCLES;
        end else if (r_decay_cnt != 22'd0) begin
            r_decay_cnt <= r_decay_cnt - 22'd1;
            if (r_decay_cnt == 22'd1) r_decay_byte <= '0;
        end
    end

    assign w_bus_hold = r_decay_byte;
`else
    assign w_bus_hold = 8'h00;
`endif

    // ---------------- read path ----------------
    logic       w_rd_active;
    logic [7:0] w_rd_mux;
    logic       r_oe;
    logic [7:0] r_dout;

    assign w_rd_active = w_phi2 && !w_notcs && w_rw;

    always_comb begin
        w_rd_mux = w_bus_hold;
        case (w_addr)
            SID_ADDR_POTX: w_rd_mux = POTX;
            SID_ADDR_POTY: w_rd_mux = POTY;
            SID_ADDR_OSC3: w_rd_mux = OSC3;
            SID_ADDR_ENV3: w_rd_mux = ENV3;
            default:       ;
        endcase
    end

    always_ff @(posedge C6_CLK_8MHZ or negedge SID_NOTRES) begin
        if (!SID_NOTRES) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_oe   <= w_rd_active;
            r_dout <= w_rd_active ? w_rd_mux : 8'h00;
        end
    end

    assign SID_DATA_OE  = r_oe;
    assign SID_DATA_OUT = r_dout;

endmodule

// File: tb/tb_sid_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_sid_bus_slave
// Directed bench for sid_bus_slave: bus writes/reads generated as explicit phi2
// periods, write strobes recorded by a monitor, expected values hand-computed.
// -----------------------------------------------------------------------------
module tb_sid_bus_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sid_clk = 1'b0, sid_notcs = 1'b1, sid_rw = 1'b1;
    logic [4:0] sid_addr = '0;
    logic [7:0] sid_din = '0;
    logic [7:0] dout;
    logic       oe;
    logic [7:0] potx = '0, poty = '0, osc3 = '0, env3 = '0;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] reg_raddr = '0;
    logic [7:0] reg_rdata;
    logic [2:0] gate;

    int checks = 0;
    int errors = 0;

    sid_bus_slave #(.SYNC_STAGES(2), .DECAY_CYCLES(22'd100)) dut (
        .C6_CLK_8MHZ  (clk),
        .SID_NOTRES   (rst_n),
        .SID_CLK      (sid_clk),
        .SID_NOTCS    (sid_notcs),
        .SID_RW       (sid_rw),
        .SID_ADDR     (sid_addr),
        .SID_DATA_IN  (sid_din),
        .SID_DATA_OUT (dout),
        .SID_DATA_OE  (oe),
        .POTX         (potx),
        .POTY         (poty),
        .OSC3         (osc3),
        .ENV3         (env3),
        .WR_STB       (wr_stb),
        .WR_ADDR      (wr_addr),
        .WR_DATA      (wr_data),
        .REG_RADDR    (reg_raddr),
        .REG_RDATA    (reg_rdata),
        .GATE         (gate)
    );

    always #5 clk = ~clk;

    // ---------------- strobe monitor (samples on falling edge) ----------------
    int         cycle_cnt = 0;
    int         stb_count = 0;
    int         stb_cycle = 0;
    logic [4:0] stb_addr = '0;
    logic [7:0] stb_data = '0;
    logic [2:0] stb_gate = '0;
    bit         stb_multi = 1'b0;
    logic       prev_stb = 1'b0;

    always @(posedge clk) cycle_cnt++;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_count++;
            stb_cycle = cycle_cnt;
            stb_addr  = wr_addr;
            stb_data  = wr_data;
            stb_gate  = gate;
            if (prev_stb === 1'b1) stb_multi = 1'b1;
        end
        prev_stb = wr_stb;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start(input logic rw, input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        sid_notcs = 1'b0; sid_rw = rw; sid_addr = addr; sid_din = data;
        tick(1);
        sid_clk = 1'b1;
        tick(8);
    endtask

    task automatic bus_fall();
        sid_clk = 1'b0;
    endtask

    task automatic bus_end();
        tick(8);
        sid_notcs = 1'b1; sid_rw = 1'b1;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [7:0] data);
        bus_start(1'b0, addr, data);
        bus_fall();
        bus_end();
    endtask

    task automatic read_reg(input logic [4:0] addr, output logic [7:0] data);
        @(negedge clk);
        reg_raddr = addr;
        @(negedge clk);
        data = reg_rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] rd;
        tick(3);
        checks++; if (wr_stb !== 1'b0) begin errors++; $display("FAIL reset_wr_stb: got %b expected 0", wr_stb); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", oe); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (gate !== 3'b000) begin errors++; $display("FAIL reset_gate: got %b expected 000", gate); end
        checks++; if (reg_rdata !== 8'h00) begin errors++; $display("FAIL reset_reg_rdata: got %h expected 00", reg_rdata); end
        rst_n = 1'b1;
        tick(2);
        read_reg(5'h18, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_reg18: got %h expected 00", rd); end
    endtask

    task automatic test_write_modevol();
        int n0 = stb_count;
        logic [7:0] rd;
        stb_multi = 1'b0;
        bus_write(5'h18, 8'h1F);
        checks++; if (stb_count - n0 !== 1) begin errors++; $display("FAIL modevol_stb_count: got %0d expected 1", stb_count - n0); end
        checks++; if (stb_multi !== 1'b0) begin errors++; $display("FAIL modevol_stb_width: got multi-cycle strobe expected single"); end
        checks++; if (stb_addr !== 5'h18) begin errors++; $display("FAIL modevol_wr_addr: got %h expected 18", stb_addr); end
        checks++; if (stb_data !== 8'h1F) begin errors++; $display("FAIL modevol_wr_data: got %h expected 1f", stb_data); end
        checks++; if (oe !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL modevol_idle_bus: got oe=%b dout=%h expected 0/00", oe, dout); end
        read_reg(5'h18, rd);
        checks++; if (rd !== 8'h1F) begin errors++; $display("FAIL modevol_reg_rdata: got %h expected 1f", rd); end
    endtask

    task automatic test_gate();
        int n0 = stb_count;
        bus_write(5'h04, 8'h11);
        checks++; if (stb_count - n0 !== 1) begin errors++; $display("FAIL gate_on_stb: got %0d expected 1", stb_count - n0); end
        checks++; if (stb_gate !== 3'b001) begin errors++; $display("FAIL gate_on_commit_cycle: got %b expected 001", stb_gate); end
        checks++; if (gate !== 3'b001) begin errors++; $display("FAIL gate_on: got %b expected 001", gate); end
        n0 = stb_count;
        bus_write(5'h04, 8'h10);
        checks++; if (stb_count - n0 !== 1) begin errors++; $display("FAIL gate_off_stb: got %0d expected 1", stb_count - n0); end
        checks++; if (stb_gate !== 3'b000) begin errors++; $display("FAIL gate_off_commit_cycle: got %b expected 000", stb_gate); end
        checks++; if (gate !== 3'b000) begin errors++; $display("FAIL gate_off: got %b expected 000", gate); end
        bus_write(5'h0B, 8'h41);
        bus_write(5'h12, 8'h81);
        checks++; if (gate !== 3'b110) begin errors++; $display("FAIL gate_v23: got %b expected 110", gate); end
    endtask

    task automatic test_abort();
        int n0;
        logic [7:0] rd;
        bus_write(5'h05, 8'h55);
        n0 = stb_count;
        @(negedge clk);
        sid_notcs = 1'b0; sid_rw = 1'b0; sid_addr = 5'h05; sid_din = 8'hAA;
        tick(1);
        sid_clk = 1'b1;
        tick(8);
        sid_notcs = 1'b1;        // deselect while phi2 still high
        tick(4);
        sid_clk = 1'b0;
        tick(8);
        sid_rw = 1'b1;
        checks++; if (stb_count - n0 !== 0) begin errors++; $display("FAIL abort_stb: got %0d expected 0", stb_count - n0); end
        read_reg(5'h05, rd);
        checks++; if (rd !== 8'h55) begin errors++; $display("FAIL abort_array: got %h expected 55", rd); end
    endtask

    task automatic test_drops();
        int n0 = stb_count;
        logic [7:0] rd;
        bus_write(5'h19, 8'h33);
        bus_write(5'h1F, 8'h44);
        bus_start(1'b1, 5'h05, 8'hEE);   // read access
        bus_fall();
        bus_end();
        checks++; if (stb_count - n0 !== 0) begin errors++; $display("FAIL drop_stb: got %0d expected 0", stb_count - n0); end
        read_reg(5'h19, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL drop_reg19: got %h expected 00", rd); end
        read_reg(5'h05, rd);
        checks++; if (rd !== 8'h55) begin errors++; $display("FAIL drop_reg05: got %h expected 55", rd); end
    endtask

    task automatic test_read();
        logic [4:0] addrs [4] = '{5'h19, 5'h1A, 5'h1B, 5'h1C};
        logic [7:0] exps  [4] = '{8'h3C, 8'hC3, 8'hA5, 8'h5E};
        potx = 8'h3C; poty = 8'hC3; osc3 = 8'hA5; env3 = 8'h5E;
        for (int i = 0; i < 4; i++) begin
            bus_start(1'b1, addrs[i], 8'h00);
            checks++; if (oe !== 1'b1) begin errors++; $display("FAIL read_oe_high[%h]: got %b expected 1", addrs[i], oe); end
            checks++; if (dout !== exps[i]) begin errors++; $display("FAIL read_data[%h]: got %h expected %h", addrs[i], dout, exps[i]); end
            bus_fall();
            tick(4);
            checks++; if (oe !== 1'b0) begin errors++; $display("FAIL read_oe_low[%h]: got %b expected 0", addrs[i], oe); end
            checks++; if (dout !== 8'h00) begin errors++; $display("FAIL read_dout_low[%h]: got %h expected 00", addrs[i], dout); end
            bus_end();
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] rd;
        bit found = 1'b0;
        read_reg(5'h09, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL collide_pre: got %h expected 00", rd); end
        bus_start(1'b0, 5'h09, 8'h5A);
        bus_fall();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (wr_stb === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL collide_stb_timeout: got no strobe expected one within 20 cycles"); end
        @(negedge clk);
        checks++; if (reg_rdata !== 8'h00) begin errors++; $display("FAIL collide_old: got %h expected 00", reg_rdata); end
        @(negedge clk);
        checks++; if (reg_rdata !== 8'h5A) begin errors++; $display("FAIL collide_new: got %h expected 5a", reg_rdata); end
        bus_end();
    endtask

    task automatic test_back_to_back();
        int n0 = stb_count;
        logic [7:0] rd;
        @(negedge clk);
        sid_notcs = 1'b0; sid_rw = 1'b0; sid_addr = 5'h07; sid_din = 8'h21;
        tick(1);
        sid_clk = 1'b1; tick(8);
        sid_clk = 1'b0; tick(4);
        sid_addr = 5'h08; sid_din = 8'h22; tick(4);
        sid_clk = 1'b1; tick(8);
        sid_clk = 1'b0; tick(8);
        sid_notcs = 1'b1; sid_rw = 1'b1;
        checks++; if (stb_count - n0 !== 2) begin errors++; $display("FAIL b2b_stb: got %0d expected 2", stb_count - n0); end
        read_reg(5'h07, rd);
        checks++; if (rd !== 8'h21) begin errors++; $display("FAIL b2b_reg07: got %h expected 21", rd); end
        read_reg(5'h08, rd);
        checks++; if (rd !== 8'h22) begin errors++; $display("FAIL b2b_reg08: got %h expected 22", rd); end
    endtask

    task automatic test_decay();
        int t0;
        logic [7:0] exp_early;
`ifdef SID_BUSDECAY_EN
        exp_early = 8'h7F;
`else
        exp_early = 8'h00;
`endif
        bus_write(5'h02, 8'h7F);
        t0 = stb_cycle;
        while (cycle_cnt < t0 + 41) @(negedge clk);
        bus_start(1'b1, 5'h02, 8'h00);   // sample lands near cycle 50
        checks++; if (oe !== 1'b1 || dout !== exp_early) begin errors++; $display("FAIL decay_early: got oe=%b dout=%h expected 1/%h", oe, dout, exp_early); end
        bus_fall();
        bus_end();
        while (cycle_cnt < t0 + 141) @(negedge clk);
        bus_start(1'b1, 5'h02, 8'h00);   // sample lands near cycle 150
        checks++; if (oe !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL decay_late: got oe=%b dout=%h expected 1/00", oe, dout); end
        bus_fall();
        bus_end();
    endtask

    task automatic test_reset_mid_access();
        int n0 = stb_count;
        logic [7:0] rd;
        @(negedge clk);
        sid_notcs = 1'b0; sid_rw = 1'b0; sid_addr = 5'h01; sid_din = 8'hFF;
        tick(1);
        sid_clk = 1'b1;
        tick(6);                 // FSM armed
        rst_n = 1'b0;
        tick(3);
        sid_clk = 1'b0;
        tick(3);
        sid_notcs = 1'b1; sid_rw = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        checks++; if (stb_count - n0 !== 0) begin errors++; $display("FAIL rstmid_stb: got %0d expected 0", stb_count - n0); end
        read_reg(5'h01, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rstmid_reg01: got %h expected 00", rd); end
        read_reg(5'h18, rd);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rstmid_reg18_cleared: got %h expected 00", rd); end
        checks++; if (gate !== 3'b000) begin errors++; $display("FAIL rstmid_gate: got %b expected 000", gate); end
        n0 = stb_count;
        bus_write(5'h01, 8'h3C);
        checks++; if (stb_count - n0 !== 1) begin errors++; $display("FAIL rstmid_next_stb: got %0d expected 1", stb_count - n0); end
        read_reg(5'h01, rd);
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL rstmid_next_reg01: got %h expected 3c", rd); end
    endtask

    initial begin
        test_reset();
        test_write_modevol();
        test_gate();
        test_abort();
        test_drops();
        test_read();
        test_same_cycle();
        test_back_to_back();
        test_decay();
        test_reset_mid_access();
        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_bus_slave.md
SID_BUS_SLAVE -- requirements
Module: sid_bus_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for all SID bus inputs (legal values 2..4).
REQ-002 SHALL have parameter DECAY_CYCLES, default 22'd2000000, giving the bus-hold decay time in C6_CLK_8MHZ cycles.
REQ-003 C6_CLK_8MHZ  in  1  system clock; the only clock.
REQ-004 SID_NOTRES  in  1  reset, asynchronous, active-low.
REQ-005 SID_CLK  in  1  phi2 from the bus master, asynchronous to C6_CLK_8MHZ.
REQ-006 SID_NOTCS  in  1  chip select, active-low.
REQ-007 SID_RW  in  1  1=read, 0=write.
REQ-008 SID_ADDR  in  5  register address.
REQ-009 SID_DATA_IN  in  8  write data from the master.
REQ-010 SID_DATA_OUT  out  8  read data to the master.
REQ-011 SID_DATA_OE  out  1  read-data output enable.
REQ-012 POTX, POTY, OSC3, ENV3  in  8 each  read-only sources for 0x19..0x1C.
REQ-013 WR_STB  out  1  one-cycle pulse per committed write; WR_ADDR  out  5; WR_DATA  out  8.
REQ-014 REG_RADDR  in  5  internal read port; REG_RDATA  out  8  registered.
REQ-015 GATE  out  3  bit 0 of registers 0x04, 0x0B and 0x12.

Function
REQ-016 SHALL pass SID_CLK, SID_NOTCS, SID_RW, SID_ADDR and SID_DATA_IN through SYNC_STAGES flops before use.
REQ-017 SHALL implement FSM IDLE->ARMED when synced phi2=1 and NOTCS=0; ARMED->COMMIT on synced phi2 falling edge with NOTCS still 0; COMMIT->IDLE after one cycle.
REQ-018 ARMED->IDLE with no write if NOTCS rises before phi2 falls (aborted access).
REQ-019 ADDR and DATA SHALL be captured on the last synced phi2=1 cycle before the fall.
REQ-020 In COMMIT with RW=0 and ADDR<=0x18: write register array[ADDR]; assert WR_STB, WR_ADDR and WR_DATA for exactly that one cycle.
REQ-021 Writes to 0x19..0x1F SHALL be dropped with no WR_STB.
REQ-022 A read access (RW=1) SHALL NOT assert WR_STB.
REQ-023 SID_DATA_OE SHALL be 1 only while synced phi2=1, NOTCS=0 and RW=1; it SHALL drop within 1 cycle after any of these ends.
REQ-024 Read data SHALL be: 0x19=POTX, 0x1A=POTY, 0x1B=OSC3, 0x1C=ENV3; all other addresses per REQ-032/033.
REQ-025 SID_DATA_OUT SHALL be 0x00 whenever SID_DATA_OE=0.
REQ-026 REG_RDATA SHALL equal array[REG_RADDR] one cycle after the address is presented; 0x00 for addresses >0x18.
REQ-027 If a REG_RADDR read and a commit hit the same address in the same cycle, REG_RDATA SHALL return the old value; the new value SHALL appear on the following cycle.
REQ-028 GATE SHALL update in the COMMIT cycle of the corresponding write.
REQ-029 At most one commit per phi2 period; back-to-back phi2 periods SHALL each commit.

Reset
REQ-030 SID_NOTRES=0 SHALL asynchronously clear the register array, the FSM (to IDLE), the synchronizers, the decay state, and all outputs to 0.
REQ-031 Reset asserted mid-access SHALL discard that access; after release, the first commit requires a fresh phi2 rising and falling edge.

Configuration
REQ-032 With SID_BUSDECAY_EN defined: a read of a write-only address (0x00..0x18, 0x1D..0x1F) SHALL return the last committed write byte; this byte SHALL clear to 0x00 after DECAY_CYCLES cycles with no commit; each commit SHALL reload the counter.
REQ-033 Without SID_BUSDECAY_EN: reads of those addresses SHALL return 0x00, and no decay counter SHALL be present.

Structure
REQ-034 Package sid_pkg SHALL hold the address constants (0x00..0x1C, including SID_ADDR_MODEVOL=0x18 and SID_ADDR_POTX..ENV3), the FSM state enum, and the register-count constant 25.
REQ-035 Sub-module sid_bus_sync SHALL implement the parameterized synchronizer and the phi2 edge detection.

Verification
REQ-036 Write 0x1F to 0x18 -> one-cycle WR_STB with WR_ADDR=0x18, WR_DATA=0x1F; REG_RADDR=0x18 then reads 0x1F.
REQ-037 Write 0x11 to 0x04, then 0x10 to 0x04 -> GATE[0] rises and then falls, one WR_STB per write.
REQ-038 NOTCS released while phi2=1, before the fall -> no WR_STB and the array is unchanged.
REQ-039 Read 0x1B with OSC3=0xA5 -> SID_DATA_OUT=0xA5 with OE=1 during phi2 high; OE=0 within 1 cycle of phi2 low.
REQ-040 SID_BUSDECAY_EN defined with DECAY_CYCLES=100: write 0x7F to 0x02, read 0x02 at cycle 50 -> 0x7F; at cycle 150 -> 0x00. Macro undefined -> 0x00 on both reads.
REQ-041 Assert reset during ARMED of a write of 0xFF to 0x01 -> array[0x01]=0x00, no WR_STB; the next full access commits normally.
